// File: rtl/frontend_read_return.sv
// frontend_read_return: buffers backend read lines, pairs each with its issue tag in order,
// and streams the line out as BURST_LEN beats under a valid/ready handshake.
module frontend_read_return #(
    parameter int WORD_W     = 64,
    parameter int BURST_LEN  = 4,
    parameter int LINE_DEPTH = 4,
    parameter int TAG_DEPTH  = 8,
    parameter int ID_W       = 4,
    parameter int CORE_W     = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_tag_push,
    input  logic [ID_W-1:0]               i_tag_id,
    input  logic [CORE_W-1:0]             i_tag_core,
    output logic                          o_tag_full,
    output logic [$clog2(TAG_DEPTH):0]    o_tag_count,
    output logic                          o_receive_ready,
    input  logic                          i_returned_data_valid,
    input  logic [BURST_LEN*WORD_W-1:0]   i_returned_data,
    input  logic                          i_interconnection_ready,
    output logic                          o_request_valid,
    output logic [WORD_W-1:0]             o_read_data,
    output logic                          o_read_data_last,
    output logic [ID_W-1:0]               o_request_id,
    output logic [CORE_W-1:0]             o_core_id
);
    localparam int TPW = $clog2(TAG_DEPTH);
    localparam int LPW = $clog2(LINE_DEPTH);
    localparam int BCW = $clog2(BURST_LEN);

    typedef enum logic {IDLE, SEND} state_e;
    state_e state_q, state_d;

    logic [BURST_LEN-1:0][WORD_W-1:0] line_mem_q [LINE_DEPTH];
    logic [ID_W+CORE_W-1:0]           tag_mem_q [TAG_DEPTH];
    logic [LPW-1:0]                   line_wr_q, line_wr_d, line_rd_q, line_rd_d;
    logic [LPW:0]                     line_cnt_q, line_cnt_d;
    logic [TPW-1:0]                   tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [TPW:0]                     tag_cnt_q, tag_cnt_d;
    logic [BURST_LEN-1:0][WORD_W-1:0] beat_q, beat_d;
    logic [BCW-1:0]                   beat_cnt_q, beat_cnt_d;
    logic [ID_W-1:0]                  id_q, id_d;
    logic [CORE_W-1:0]                core_q, core_d;
    logic                             line_push, tag_push, load, xfer, beat_last;

    assign o_tag_full      = tag_cnt_q == (TPW+1)'(TAG_DEPTH);
    assign o_tag_count     = tag_cnt_q;
    assign o_receive_ready = line_cnt_q != (LPW+1)'(LINE_DEPTH);

    always_comb begin
        line_push  = i_returned_data_valid && o_receive_ready;
        xfer       = o_request_valid && i_interconnection_ready;
        beat_last  = beat_cnt_q == BCW'(BURST_LEN-1);
        load       = (line_cnt_q != '0) && (tag_cnt_q != '0) && (state_q == IDLE || (xfer && beat_last));
        // A pop frees the head slot this cycle, so a push can land even at full.
        tag_push   = i_tag_push && (!o_tag_full || load);
        line_wr_d  = !line_push ? line_wr_q : (line_wr_q == LPW'(LINE_DEPTH-1)) ? '0 : line_wr_q + 1'b1;
        line_rd_d  = !load ? line_rd_q : (line_rd_q == LPW'(LINE_DEPTH-1)) ? '0 : line_rd_q + 1'b1;
        line_cnt_d = line_cnt_q + (LPW+1)'(line_push) - (LPW+1)'(load);
        tag_wr_d   = tag_push ? tag_wr_q + 1'b1 : tag_wr_q;
        tag_rd_d   = load ? tag_rd_q + 1'b1 : tag_rd_q;
        tag_cnt_d  = tag_cnt_q + (TPW+1)'(tag_push) - (TPW+1)'(load);
        beat_d     = load ? line_mem_q[line_rd_q] : beat_q;
        {id_d, core_d} = load ? tag_mem_q[tag_rd_q] : {id_q, core_q};
        beat_cnt_d = load ? '0 : (xfer && !beat_last) ? beat_cnt_q + 1'b1 : xfer ? '0 : beat_cnt_q;
    end

    always_comb begin
        state_d = load ? SEND : (xfer && beat_last) ? IDLE : state_q;
    end

    always_comb begin
        o_request_valid  = state_q == SEND;
        o_read_data      = beat_q[beat_cnt_q];
        o_read_data_last = o_request_valid && beat_last;
        o_request_id     = id_q;
        o_core_id        = core_q;
    end

    always_ff @(posedge i_clk) begin
        if (line_push) line_mem_q[line_wr_q] <= i_returned_data;
        if (tag_push)  tag_mem_q[tag_wr_q]   <= {i_tag_id, i_tag_core};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            line_wr_q  <= '0;
            line_rd_q  <= '0;
            line_cnt_q <= '0;
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
            tag_cnt_q  <= '0;
            beat_q     <= '0;
            beat_cnt_q <= '0;
            id_q       <= '0;
            core_q     <= '0;
        end else begin
            state_q    <= state_d;
            line_wr_q  <= line_wr_d;
            line_rd_q  <= line_rd_d;
            line_cnt_q <= line_cnt_d;
            tag_wr_q   <= tag_wr_d;
            tag_rd_q   <= tag_rd_d;
            tag_cnt_q  <= tag_cnt_d;
            beat_q     <= beat_d;
            beat_cnt_q <= beat_cnt_d;
            id_q       <= id_d;
            core_q     <= core_d;
        end
    end
endmodule

// File: tb/tb_frontend_read_return.sv
// tb_frontend_read_return: directed scenarios for frontend_read_return; inputs change and
// outputs are sampled on the falling edge.
module tb_frontend_read_return;
    logic         clk = 1'b0, rst_n = 1'b0;
    logic         tag_push = 1'b0, rdv = 1'b0, ready = 1'b1;
    logic [3:0]   tag_id = '0;
    logic [1:0]   tag_core = '0;
    logic [255:0] rdata = '0;
    logic         tag_full, recv_ready, valid, last;
    logic [3:0]   tag_count, id;
    logic [1:0]   core;
    logic [63:0]  data;
    logic [71:0]  obs, e;
    int           total = 0, bad = 0;

    frontend_read_return dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_tag_push(tag_push), .i_tag_id(tag_id), .i_tag_core(tag_core),
        .o_tag_full(tag_full), .o_tag_count(tag_count), .o_receive_ready(recv_ready),
        .i_returned_data_valid(rdv), .i_returned_data(rdata), .i_interconnection_ready(ready),
        .o_request_valid(valid), .o_read_data(data), .o_read_data_last(last),
        .o_request_id(id), .o_core_id(core)
    );

    always #5 clk = ~clk;
    assign obs = {valid, last, id, core, data};

    function automatic logic [63:0] wd(input logic [15:0] b, input int k);
        return {48'hBEEF_CAFE_0000, b + 16'(k)};
    endfunction

    function automatic logic [255:0] mk(input logic [15:0] b);
        return {wd(b, 3), wd(b, 2), wd(b, 1), wd(b, 0)};
    endfunction

    task automatic test_reset;
        repeat (2) @(negedge clk);
        total++; if (obs !== 72'd0) begin bad++; $display("FAIL reset_outs got=%h exp=0", obs); end
        total++; if ({recv_ready, tag_full, tag_count} !== 6'b100000) begin bad++; $display("FAIL reset_status got=%b exp=100000", {recv_ready, tag_full, tag_count}); end
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        @(negedge clk); tag_push = 1; tag_id = 5; tag_core = 2;
        @(negedge clk); tag_push = 0;
        total++; if (tag_count !== 4'd1) begin bad++; $display("FAIL single_tagcnt got=%0d exp=1", tag_count); end
        rdv = 1; rdata = mk(16'h0100);
        @(negedge clk); rdv = 0;
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL single_early_valid got=%b exp=0", valid); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            e = {1'b1, k == 3, 4'd5, 2'd2, wd(16'h0100, k)};
            total++; if (obs !== e) begin bad++; $display("FAIL single_beat%0d got=%h exp=%h", k, obs, e); end
        end
        @(negedge clk);
        total++; if ({valid, tag_count} !== 5'd0) begin bad++; $display("FAIL single_end got=%b exp=00000", {valid, tag_count}); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk); tag_push = 1; tag_id = 1; tag_core = 0;
        @(negedge clk); tag_id = 2; tag_core = 1;
        @(negedge clk); tag_push = 0; rdv = 1; rdata = mk(16'h0200);
        @(negedge clk); rdata = mk(16'h0300);
        @(negedge clk); rdv = 0;
        for (int j = 0; j < 8; j++) begin
            if (j > 0) @(negedge clk);
            e = {1'b1, j % 4 == 3, j < 4 ? 4'd1 : 4'd2, j < 4 ? 2'd0 : 2'd1, wd(j < 4 ? 16'h0200 : 16'h0300, j % 4)};
            total++; if (obs !== e) begin bad++; $display("FAIL b2b_beat%0d got=%h exp=%h", j, obs, e); end
        end
        @(negedge clk);
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL b2b_end_valid got=%b exp=0", valid); end
    endtask

    task automatic test_backpressure;
        @(negedge clk); tag_push = 1; tag_id = 3; tag_core = 1;
        @(negedge clk); tag_push = 0; rdv = 1; rdata = mk(16'h0400);
        @(negedge clk); rdv = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            e = {1'b1, 1'b0, 4'd3, 2'd1, wd(16'h0400, k)};
            total++; if (obs !== e) begin bad++; $display("FAIL bp_beat%0d got=%h exp=%h", k, obs, e); end
        end
        ready = 0;
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            e = {1'b1, 1'b0, 4'd3, 2'd1, wd(16'h0400, 2)};
            total++; if (obs !== e) begin bad++; $display("FAIL bp_hold%0d got=%h exp=%h", r, obs, e); end
        end
        ready = 1;
        @(negedge clk);
        e = {1'b1, 1'b1, 4'd3, 2'd1, wd(16'h0400, 3)};
        total++; if (obs !== e) begin bad++; $display("FAIL bp_last got=%h exp=%h", obs, e); end
        @(negedge clk);
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL bp_end_valid got=%b exp=0", valid); end
    endtask

    task automatic test_full_late_tag;
        ready = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); rdv = 1; rdata = mk(16'h1000 + 16'(i * 256));
        end
        @(negedge clk);
        total++; if (recv_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", recv_ready); end
        rdata = mk(16'h1400);
        @(negedge clk);
        total++; if ({recv_ready, valid} !== 2'b00) begin bad++; $display("FAIL full_notag got=%b exp=00", {recv_ready, valid}); end
        rdv = 0; tag_push = 1; tag_id = 7; tag_core = 3;
        @(negedge clk); tag_push = 0;
        total++; if (recv_ready !== 1'b0) begin bad++; $display("FAIL full_prepop_ready got=%b exp=0", recv_ready); end
        @(negedge clk);
        total++; if (recv_ready !== 1'b1) begin bad++; $display("FAIL full_postpop_ready got=%b exp=1", recv_ready); end
        ready = 1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            e = {1'b1, k == 3, 4'd7, 2'd3, wd(16'h1000, k)};
            total++; if (obs !== e) begin bad++; $display("FAIL late_beat%0d got=%h exp=%h", k, obs, e); end
        end
        @(negedge clk);
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL late_end_valid got=%b exp=0", valid); end
        ready = 0;
        for (int i = 0; i < 3; i++) begin
            tag_push = 1; tag_id = 4'(8 + i); tag_core = 2'(i);
            @(negedge clk);
        end
        tag_push = 0; ready = 1;
        total++; if (tag_count !== 4'd2) begin bad++; $display("FAIL drain_tagcnt got=%0d exp=2", tag_count); end
        for (int j = 0; j < 12; j++) begin
            if (j > 0) @(negedge clk);
            e = {1'b1, j % 4 == 3, 4'(8 + j / 4), 2'(j / 4), wd(16'h1100 + 16'((j / 4) * 256), j % 4)};
            total++; if (obs !== e) begin bad++; $display("FAIL drain_beat%0d got=%h exp=%h", j, obs, e); end
        end
        @(negedge clk);
        total++; if ({valid, recv_ready, tag_count} !== 6'b010000) begin bad++; $display("FAIL drain_end got=%b exp=010000", {valid, recv_ready, tag_count}); end
    endtask

    task automatic test_tag_full;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); tag_push = 1; tag_id = 4'(i); tag_core = 2'(i % 4);
        end
        @(negedge clk);
        total++; if ({tag_full, tag_count} !== 5'b11000) begin bad++; $display("FAIL tagfull_state got=%b exp=11000", {tag_full, tag_count}); end
        tag_id = 15; tag_core = 3;
        @(negedge clk); tag_push = 0;
        total++; if (tag_count !== 4'd8) begin bad++; $display("FAIL tagfull_drop got=%0d exp=8", tag_count); end
        rdv = 1; rdata = mk(16'h2000);
        @(negedge clk); rdv = 0; tag_push = 1; tag_id = 14; tag_core = 0;
        @(negedge clk); tag_push = 0;
        total++; if ({tag_full, tag_count} !== 5'b11000) begin bad++; $display("FAIL tagfull_pushpop got=%b exp=11000", {tag_full, tag_count}); end
        e = {1'b1, 1'b0, 4'd0, 2'd0, wd(16'h2000, 0)};
        total++; if (obs !== e) begin bad++; $display("FAIL tagfull_beat0 got=%h exp=%h", obs, e); end
    endtask

    task automatic test_reset_mid_burst;
        @(negedge clk);
        e = {1'b1, 1'b0, 4'd0, 2'd0, wd(16'h2000, 1)};
        total++; if (obs !== e) begin bad++; $display("FAIL rstmid_beat1 got=%h exp=%h", obs, e); end
        rst_n = 0;
        #1;
        total++; if (obs !== 72'd0) begin bad++; $display("FAIL rstmid_outs got=%h exp=0", obs); end
        total++; if ({recv_ready, tag_full, tag_count} !== 6'b100000) begin bad++; $display("FAIL rstmid_status got=%b exp=100000", {recv_ready, tag_full, tag_count}); end
        @(negedge clk); rst_n = 1;
        repeat (3) @(negedge clk);
        total++; if ({valid, recv_ready, tag_count} !== 6'b010000) begin bad++; $display("FAIL rstmid_noreplay got=%b exp=010000", {valid, recv_ready, tag_count}); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_full_late_tag();
        test_tag_full();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
